// File: rtl/main_mem_pkg.sv
// Shared constants for the main-memory responder: word width, default geometry,
// wait-counter width and the IDLE/BUSY/RESP state encoding.
package main_mem_pkg;

  localparam int WORD_W      = 32;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_LATENCY = 4;
  localparam int CNT_W       = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } resp_t;

endpackage

// File: rtl/main_mem_responder_if.sv
// Request/response bus between a cache (master) and the main-memory responder (slave).
interface main_mem_responder_if;
  import main_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/main_mem_array.sv
// Single-port DEPTH x 32 backing store: synchronous write, asynchronous read.
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory model answering cache miss/writeback requests.
// Optional MAIN_MEM_RANGE_CHECK_EN flags out-of-range or misaligned addresses.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  main_mem_responder_if.slave  bus,
  output logic [31:0]          read_count,
  output logic [31:0]          write_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_wait;
  logic [WORD_W-1:0] r_rdata;
  logic              r_err;
  logic [31:0]       r_read_count;
  logic [31:0]       r_write_count;

  logic              w_accept;
  logic              w_addr_err;
  logic              w_we;
  logic              w_resp_valid;
  logic [AW-1:0]     w_index;
  logic [WORD_W-1:0] w_mem_rdata;

  // Reset wins over a handshake in the same cycle, so it also blocks the array write.
  assign bus.req_ready = (r_state == ST_IDLE);
  assign w_accept      = bus.req_valid && (r_state == ST_IDLE) && !rst;
  assign w_index       = bus.req_addr[AW+1:2];

`ifdef MAIN_MEM_RANGE_CHECK_EN
  assign w_addr_err = (bus.req_addr[31:AW+2] != '0) || (bus.req_addr[1:0] != 2'b00);
`else
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
  assign w_addr_err         = 1'b0;
`endif

  assign w_we = w_accept && bus.req_write && !w_addr_err;

  main_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_addr (w_index),
    .i_wdata(bus.req_wdata),
    .o_rdata(w_mem_rdata)
  );

  // Response data is captured at acceptance and held until the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wait        <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rdata <= (bus.req_write || w_addr_err) ? '0 : w_mem_rdata;
            r_err   <= w_addr_err;
            if (bus.req_write) begin
              r_write_count <= r_write_count + 32'd1;
            end else begin
              r_read_count <= r_read_count + 32'd1;
            end
            if (LATENCY == 1) begin
              r_state <= ST_RESP;
              r_wait  <= '0;
            end else begin
              r_state <= ST_BUSY;
              r_wait  <= WAIT_LOAD;
            end
          end
        end
        ST_BUSY: begin
          // Entering RESP on the 1->0 step makes resp_valid sampled LATENCY edges after acceptance.
          if (r_wait <= CNT_W'(1)) begin
            r_state <= ST_RESP;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wait  <= '0;
        end
      endcase
    end
  end

  assign w_resp_valid   = (r_state == ST_RESP);
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = w_resp_valid ? r_rdata : '0;
  assign bus.resp_err   = w_resp_valid ? r_err : 1'b0;
  assign read_count     = r_read_count;
  assign write_count    = r_write_count;

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter: DEPTH, 1024, number of 32-bit words in the backing store (power of two).
REQ-002 SHALL have parameter: LATENCY, 4, cycles from request acceptance to resp_valid (legal range 1..15).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port: req_valid  input  1  cache miss/writeback request present.
REQ-006 SHALL have port: req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port: req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: req_addr  input  32  byte address; word index = req_addr[log2(DEPTH)+1:2].
REQ-009 SHALL have port: req_wdata  input  32  write data.
REQ-010 SHALL have port: resp_valid  output  1  response available.
REQ-011 SHALL have port: resp_ready  input  1  cache consumes the response.
REQ-012 SHALL have port: resp_rdata  output  32  read data; 0 for writes.
REQ-013 SHALL have port: resp_err  output  1  address out of range (see Configuration).
REQ-014 SHALL have port: read_count  output  32  accepted reads.
REQ-015 SHALL have port: write_count  output  32  accepted writes.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a request is accepted at a posedge with req_valid && req_ready.
REQ-018 SHALL, on acceptance: perform the write into the array (writes); capture the read data (reads); capture the error flag; enter BUSY with wait counter = LATENCY-1.
REQ-019 SHALL decrement the counter in BUSY and enter RESP when it reaches 0; with LATENCY=1, go IDLE -> RESP directly.
REQ-020 SHALL assert resp_valid exactly LATENCY cycles after the acceptance edge, and hold resp_valid, resp_rdata, resp_err stable until resp_ready is high at a posedge.
REQ-021 SHALL return to IDLE on the response handshake edge; req_ready is high in the next cycle (one idle cycle between back-to-back transactions).
REQ-022 SHALL drive resp_rdata = 0 and resp_err = 0 whenever resp_valid = 0.
REQ-023 SHALL increment read_count/write_count by 1 at each acceptance edge, wrapping modulo 2^32.
REQ-024 SHALL ignore req_* while not in IDLE; resp_ready outside RESP has no effect.

Reset
REQ-025 SHALL, on rst at a posedge, enter IDLE and clear the counter, resp_valid, resp_rdata, resp_err, read_count and write_count, taking priority over any handshake in the same cycle.
REQ-026 SHALL abort an in-flight transaction on reset with no response; an already-performed write stays in the array.
REQ-027 SHALL leave array contents unchanged by reset.

Configuration
REQ-028 SHALL support macro MAIN_MEM_RANGE_CHECK_EN.
REQ-029 SHALL, when MAIN_MEM_RANGE_CHECK_EN is defined, flag req_addr >= DEPTH*4 or req_addr[1:0] != 0 as an error: the write is suppressed, read data is 0, and resp_err = 1 with the response; counters still increment.
REQ-030 SHALL, when MAIN_MEM_RANGE_CHECK_EN is undefined, tie resp_err to 0 and ignore the upper and low address bits (the index wraps).

Structure
REQ-031 SHALL place the state encoding, default DEPTH/LATENCY constants and word width in package main_mem_pkg.
REQ-032 SHALL instantiate one sub-module, main_mem_array: single-port, synchronous write, asynchronous read, DEPTH x 32.

Verification
REQ-033 SHALL cover: reset, then write 0x0000_0010 <- 0xDEADBEEF, then read 0x10 -> write response after 4 cycles with rdata 0; read response rdata 0xDEADBEEF; write_count = 1, read_count = 1.
REQ-034 SHALL cover: read with resp_ready held low 6 cycles -> resp_valid and data stable throughout; req_ready = 0 until the cycle after the handshake.
REQ-035 SHALL cover: LATENCY=1 -> resp_valid on the first cycle after acceptance; back-to-back reads complete every 2 cycles when resp_ready is tied high.
REQ-036 SHALL cover: rst asserted in BUSY -> no response, req_ready = 1 the next cycle, counters = 0; a prior write remains readable.
REQ-037 SHALL cover: MAIN_MEM_RANGE_CHECK_EN with DEPTH=1024, write to 0x1000 -> resp_err = 1, word 0 unchanged; read 0x0002 -> resp_err = 1, rdata 0. Without the macro, write to 0x1000 aliases to word 0.
REQ-038 SHALL cover: write_count preset via 0xFFFFFFFF writes (or forced) plus one write -> wraps to 0.
